// File: rtl/datapath_control_unit_if.sv
// Control-strobe bundle between the hardwired control unit and the 32-bit datapath.
// The master drives the strobes; the slave (datapath) supplies IR, CON_FF and Stop.
interface datapath_control_unit_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;

  logic        PCout, Zlowout, MDRout, InPortout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic        CONin, OutportIn;
  logic        Read, Write;
  logic [4:0]  ALU_Control;
  logic        Run;
  logic [3:0]  state_dbg;

  // Handshake: none. Every strobe is a level valid for exactly the current clk
  // cycle; the datapath acts on it at the next rising edge, with no back-pressure.
  modport master (
    input  IR, CON_FF, Stop,
    output PCout, Zlowout, MDRout, InPortout,
    output MARin, Zin, PCin, MDRin, IRin, Yin,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output CONin, OutportIn, Read, Write, ALU_Control, Run, state_dbg
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  PCout, Zlowout, MDRout, InPortout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    input  CONin, OutportIn, Read, Write, ALU_Control, Run, state_dbg
  );
endinterface

// File: rtl/datapath_control_unit.sv
// Hardwired Moore control unit: steps the datapath through a 3-cycle fetch and
// an opcode-dependent execute sequence, decoding strobes from state and IR.
module datapath_control_unit #(
  parameter logic [4:0] ALU_ADD = 5'd3,
  parameter logic [4:0] ALU_INC = 5'd12
) (
  input  logic                      clk,
  input  logic                      clr,
  datapath_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic       is_rtype, is_imm, is_negnot, is_addr;
  logic [3:0] exec_len;
  logic [3:0] step_idx;
  logic       in_exec, is_last;
  logic       unused_ir;

  assign opcode    = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  assign is_rtype  = (opcode >= 5'd3)  && (opcode <= 5'd11);
  assign is_imm    = (opcode >= 5'd12) && (opcode <= 5'd14);
  assign is_negnot = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_addr   = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);

  // Number of execute cycles (T3 onward) for the instruction currently in IR.
  always_comb begin
    exec_len = 4'd1;
    if (is_rtype || is_imm || opcode == OP_LDI) exec_len = 4'd3;
    else if (is_negnot)                          exec_len = 4'd2;
    else if (opcode == OP_LD || opcode == OP_ST) exec_len = 4'd5;
    else if (opcode == OP_BR)                    exec_len = 4'd4;
  end

  assign in_exec  = (state_q >= S_T3) && (state_q <= S_T7);
  assign step_idx = state_q - S_T3;
  assign is_last  = in_exec && (step_idx == exec_len - 4'd1);

  // Stop only matters on the way into T0, so a running instruction always completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:   state_d = bus.Stop ? S_HALT : S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_HALT:  state_d = S_HALT;
      default: begin
        if (is_last) begin
          if (opcode == OP_HALT) state_d = S_HALT;
          else                   state_d = bus.Stop ? S_HALT : S_T0;
        end else begin
          state_d = state_t'(state_q + 4'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) state_q <= S_RST;
    else      state_q <= state_d;
  end

  assign bus.state_dbg = state_q;

  always_comb begin
    bus.PCout       = 1'b0;
    bus.Zlowout     = 1'b0;
    bus.MDRout      = 1'b0;
    bus.InPortout   = 1'b0;
    bus.MARin       = 1'b0;
    bus.Zin         = 1'b0;
    bus.PCin        = 1'b0;
    bus.MDRin       = 1'b0;
    bus.IRin        = 1'b0;
    bus.Yin         = 1'b0;
    bus.Gra         = 1'b0;
    bus.Grb         = 1'b0;
    bus.Grc         = 1'b0;
    bus.Rin         = 1'b0;
    bus.Rout        = 1'b0;
    bus.BAout       = 1'b0;
    bus.Cout        = 1'b0;
    bus.CONin       = 1'b0;
    bus.OutportIn   = 1'b0;
    bus.Read        = 1'b0;
    bus.Write       = 1'b0;
    bus.ALU_Control = 5'd0;
    bus.Run         = (state_q >= S_T0) && (state_q <= S_T7);

    unique case (state_q)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.Zin = 1'b1;
        bus.ALU_Control = ALU_INC;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      default: begin
        if (is_rtype || is_imm) begin
          if (state_q == S_T3) begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end else if (state_q == S_T4) begin
            bus.Grc  = is_rtype; bus.Rout = is_rtype; bus.Cout = is_imm;
            bus.ALU_Control = opcode; bus.Zin = 1'b1;
          end else if (state_q == S_T5) begin
            bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
        end else if (is_negnot) begin
          if (state_q == S_T3) begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ALU_Control = opcode; bus.Zin = 1'b1;
          end else if (state_q == S_T4) begin
            bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
        end else if (is_addr) begin
          // ld/ldi/st share the effective-address computation (Rb or 0, plus C).
          if (state_q == S_T3) begin
            bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
          end else if (state_q == S_T4) begin
            bus.Cout = 1'b1; bus.ALU_Control = ALU_ADD; bus.Zin = 1'b1;
          end else if (state_q == S_T5) begin
            bus.Zlowout = 1'b1;
            if (opcode == OP_LDI) begin
              bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else begin
              bus.MARin = 1'b1;
            end
          end else if (state_q == S_T6) begin
            bus.MDRin = 1'b1;
            if (opcode == OP_LD) bus.Read = 1'b1;
            else begin
              bus.Gra = 1'b1; bus.Rout = 1'b1;
            end
          end else if (state_q == S_T7) begin
            if (opcode == OP_LD) begin
              bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else begin
              bus.Write = 1'b1;
            end
          end
        end else if (opcode == OP_BR) begin
          if (state_q == S_T3) begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
          end else if (state_q == S_T4) begin
            bus.PCout = 1'b1; bus.Yin = 1'b1;
          end else if (state_q == S_T5) begin
            bus.Cout = 1'b1; bus.ALU_Control = ALU_ADD; bus.Zin = 1'b1;
          end else if (state_q == S_T6) begin
            bus.Zlowout = bus.CON_FF; bus.PCin = bus.CON_FF;
          end
        end else if (state_q == S_T3) begin
          if (opcode == OP_JR) begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
          end else if (opcode == OP_IN) begin
            bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end else if (opcode == OP_OUT) begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutportIn = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed-vector bench for datapath_control_unit: one vector per clock cycle,
// with hand-computed strobe patterns, plus hand-written stop/halt/reset sequences.
module tb_datapath_control_unit;

  logic clk;
  logic clr;
  datapath_control_unit_if dif ();

  datapath_control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (dif)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of all 1-bit outputs (bit 0 = Run).
  localparam logic [21:0] B_PCOUT  = 22'h1 << 21;
  localparam logic [21:0] B_ZLOW   = 22'h1 << 20;
  localparam logic [21:0] B_MDROUT = 22'h1 << 19;
  localparam logic [21:0] B_INPORT = 22'h1 << 18;
  localparam logic [21:0] B_MARIN  = 22'h1 << 17;
  localparam logic [21:0] B_ZIN    = 22'h1 << 16;
  localparam logic [21:0] B_PCIN   = 22'h1 << 15;
  localparam logic [21:0] B_MDRIN  = 22'h1 << 14;
  localparam logic [21:0] B_IRIN   = 22'h1 << 13;
  localparam logic [21:0] B_YIN    = 22'h1 << 12;
  localparam logic [21:0] B_GRA    = 22'h1 << 11;
  localparam logic [21:0] B_GRB    = 22'h1 << 10;
  localparam logic [21:0] B_GRC    = 22'h1 << 9;
  localparam logic [21:0] B_RIN    = 22'h1 << 8;
  localparam logic [21:0] B_ROUT   = 22'h1 << 7;
  localparam logic [21:0] B_BAOUT  = 22'h1 << 6;
  localparam logic [21:0] B_COUT   = 22'h1 << 5;
  localparam logic [21:0] B_CONIN  = 22'h1 << 4;
  localparam logic [21:0] B_OUTIN  = 22'h1 << 3;
  localparam logic [21:0] B_READ   = 22'h1 << 2;
  localparam logic [21:0] B_WRITE  = 22'h1 << 1;
  localparam logic [21:0] B_RUN    = 22'h1;
  localparam logic [21:0] NONE     = 22'h0;

  localparam logic [21:0] F0 = B_PCOUT | B_MARIN | B_ZIN | B_RUN;
  localparam logic [21:0] F1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [21:0] F2 = B_MDROUT | B_IRIN | B_RUN;
  localparam logic [21:0] WB = B_ZLOW | B_GRA | B_RIN | B_RUN;

  localparam logic [31:0] I_JR   = 32'hA1000000;
  localparam logic [31:0] I_ADD  = 32'h18A20000;
  localparam logic [31:0] I_ANDI = 32'h68800005;
  localparam logic [31:0] I_NEG  = 32'h88800000;
  localparam logic [31:0] I_NOT  = 32'h90800000;
  localparam logic [31:0] I_LDI  = 32'h08800010;
  localparam logic [31:0] I_LD   = 32'h00800010;
  localparam logic [31:0] I_ST   = 32'h10800010;
  localparam logic [31:0] I_BR   = 32'h98800004;
  localparam logic [31:0] I_IN   = 32'hB0800000;
  localparam logic [31:0] I_OUT  = 32'hB8800000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_UND  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic [21:0] sig;
    logic [4:0]  alu;
    logic [63:0] name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_fail;

  logic [21:0] act_sig;
  assign act_sig = {dif.PCout, dif.Zlowout, dif.MDRout, dif.InPortout,
                    dif.MARin, dif.Zin, dif.PCin, dif.MDRin, dif.IRin, dif.Yin,
                    dif.Gra, dif.Grb, dif.Grc, dif.Rin, dif.Rout, dif.BAout, dif.Cout,
                    dif.CONin, dif.OutportIn, dif.Read, dif.Write, dif.Run};

  // driver tasks
  task automatic add(input logic c, input logic [31:0] ir, input logic con,
                     input logic stop, input logic [21:0] sig, input logic [4:0] alu,
                     input logic [63:0] name);
    vec_t v;
    v.clr = c; v.ir = ir; v.con_ff = con; v.stop = stop;
    v.sig = sig; v.alu = alu; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] ir, input logic con);
    add(1'b1, ir, con, 1'b0, F0, 5'd12, "fetch_t0");
    add(1'b1, ir, con, 1'b0, F1, 5'd0,  "fetch_t1");
    add(1'b1, ir, con, 1'b0, F2, 5'd0,  "fetch_t2");
  endtask

  // Drive one cycle's inputs after the falling edge, then check the outputs.
  task automatic apply(input vec_t v);
    @(negedge clk);
    clr        = v.clr;
    dif.IR     = v.ir;
    dif.CON_FF = v.con_ff;
    dif.Stop   = v.stop;
    #1;
    n_vec++;
    if (act_sig !== v.sig || dif.ALU_Control !== v.alu) begin
      n_fail++;
      $display("FAIL %0s @%0t: got sig=%b alu=%0d, expected sig=%b alu=%0d",
               v.name, $time, act_sig, dif.ALU_Control, v.sig, v.alu);
    end
  endtask

  task automatic chk(input logic c, input logic [31:0] ir, input logic con,
                     input logic stop, input logic [21:0] sig, input logic [4:0] alu,
                     input logic [63:0] name);
    vec_t v;
    v.clr = c; v.ir = ir; v.con_ff = con; v.stop = stop;
    v.sig = sig; v.alu = alu; v.name = name;
    apply(v);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    clr        = 1'b0;
    dif.IR     = 32'h0;
    dif.CON_FF = 1'b0;
    dif.Stop   = 1'b0;

    // Reset held for two edges, then released.
    add(1'b0, 32'h0, 1'b0, 1'b0, NONE, 5'd0, "rst_hold");
    add(1'b1, 32'h0, 1'b0, 1'b0, NONE, 5'd0, "rst_rel");

    add_fetch(I_JR, 1'b0);
    add(1'b1, I_JR, 1'b0, 1'b0, B_GRA | B_ROUT | B_PCIN | B_RUN, 5'd0, "jr_t3");

    add_fetch(I_ADD, 1'b0);
    add(1'b1, I_ADD, 1'b0, 1'b0, B_GRB | B_ROUT | B_YIN | B_RUN, 5'd0, "add_t3");
    add(1'b1, I_ADD, 1'b0, 1'b0, B_GRC | B_ROUT | B_ZIN | B_RUN, 5'd3, "add_t4");
    add(1'b1, I_ADD, 1'b0, 1'b0, WB, 5'd0, "add_t5");

    add_fetch(I_ANDI, 1'b0);
    add(1'b1, I_ANDI, 1'b0, 1'b0, B_GRB | B_ROUT | B_YIN | B_RUN, 5'd0, "andi_t3");
    add(1'b1, I_ANDI, 1'b0, 1'b0, B_COUT | B_ZIN | B_RUN, 5'd13, "andi_t4");
    add(1'b1, I_ANDI, 1'b0, 1'b0, WB, 5'd0, "andi_t5");

    add_fetch(I_NEG, 1'b0);
    add(1'b1, I_NEG, 1'b0, 1'b0, B_GRB | B_ROUT | B_ZIN | B_RUN, 5'd17, "neg_t3");
    add(1'b1, I_NEG, 1'b0, 1'b0, WB, 5'd0, "neg_t4");

    add_fetch(I_NOT, 1'b0);
    add(1'b1, I_NOT, 1'b0, 1'b0, B_GRB | B_ROUT | B_ZIN | B_RUN, 5'd18, "not_t3");
    add(1'b1, I_NOT, 1'b0, 1'b0, WB, 5'd0, "not_t4");

    add_fetch(I_LDI, 1'b0);
    add(1'b1, I_LDI, 1'b0, 1'b0, B_GRB | B_BAOUT | B_YIN | B_RUN, 5'd0, "ldi_t3");
    add(1'b1, I_LDI, 1'b0, 1'b0, B_COUT | B_ZIN | B_RUN, 5'd3, "ldi_t4");
    add(1'b1, I_LDI, 1'b0, 1'b0, WB, 5'd0, "ldi_t5");

    add_fetch(I_LD, 1'b0);
    add(1'b1, I_LD, 1'b0, 1'b0, B_GRB | B_BAOUT | B_YIN | B_RUN, 5'd0, "ld_t3");
    add(1'b1, I_LD, 1'b0, 1'b0, B_COUT | B_ZIN | B_RUN, 5'd3, "ld_t4");
    add(1'b1, I_LD, 1'b0, 1'b0, B_ZLOW | B_MARIN | B_RUN, 5'd0, "ld_t5");
    add(1'b1, I_LD, 1'b0, 1'b0, B_READ | B_MDRIN | B_RUN, 5'd0, "ld_t6");
    add(1'b1, I_LD, 1'b0, 1'b0, B_MDROUT | B_GRA | B_RIN | B_RUN, 5'd0, "ld_t7");

    add_fetch(I_ST, 1'b0);
    add(1'b1, I_ST, 1'b0, 1'b0, B_GRB | B_BAOUT | B_YIN | B_RUN, 5'd0, "st_t3");
    add(1'b1, I_ST, 1'b0, 1'b0, B_COUT | B_ZIN | B_RUN, 5'd3, "st_t4");
    add(1'b1, I_ST, 1'b0, 1'b0, B_ZLOW | B_MARIN | B_RUN, 5'd0, "st_t5");
    add(1'b1, I_ST, 1'b0, 1'b0, B_GRA | B_ROUT | B_MDRIN | B_RUN, 5'd0, "st_t6");
    add(1'b1, I_ST, 1'b0, 1'b0, B_WRITE | B_RUN, 5'd0, "st_t7");

    add_fetch(I_BR, 1'b1);
    add(1'b1, I_BR, 1'b1, 1'b0, B_GRA | B_ROUT | B_CONIN | B_RUN, 5'd0, "br1_t3");
    add(1'b1, I_BR, 1'b1, 1'b0, B_PCOUT | B_YIN | B_RUN, 5'd0, "br1_t4");
    add(1'b1, I_BR, 1'b1, 1'b0, B_COUT | B_ZIN | B_RUN, 5'd3, "br1_t5");
    add(1'b1, I_BR, 1'b1, 1'b0, B_ZLOW | B_PCIN | B_RUN, 5'd0, "br1_t6");

    add_fetch(I_BR, 1'b0);
    add(1'b1, I_BR, 1'b0, 1'b0, B_GRA | B_ROUT | B_CONIN | B_RUN, 5'd0, "br0_t3");
    add(1'b1, I_BR, 1'b0, 1'b0, B_PCOUT | B_YIN | B_RUN, 5'd0, "br0_t4");
    add(1'b1, I_BR, 1'b0, 1'b0, B_COUT | B_ZIN | B_RUN, 5'd3, "br0_t5");
    add(1'b1, I_BR, 1'b0, 1'b0, B_RUN, 5'd0, "br0_t6");

    add_fetch(I_IN, 1'b0);
    add(1'b1, I_IN, 1'b0, 1'b0, B_INPORT | B_GRA | B_RIN | B_RUN, 5'd0, "in_t3");
    add_fetch(I_OUT, 1'b0);
    add(1'b1, I_OUT, 1'b0, 1'b0, B_GRA | B_ROUT | B_OUTIN | B_RUN, 5'd0, "out_t3");
    add_fetch(I_NOP, 1'b0);
    add(1'b1, I_NOP, 1'b0, 1'b0, B_RUN, 5'd0, "nop_t3");
    add_fetch(I_UND, 1'b0);
    add(1'b1, I_UND, 1'b0, 1'b0, B_RUN, 5'd0, "und_t3");

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Stop raised during T2 of an add: the add finishes, then HALT.
    chk(1'b1, I_ADD, 1'b0, 1'b0, F0, 5'd12, "stp_t0");
    chk(1'b1, I_ADD, 1'b0, 1'b0, F1, 5'd0,  "stp_t1");
    chk(1'b1, I_ADD, 1'b0, 1'b1, F2, 5'd0,  "stp_t2");
    chk(1'b1, I_ADD, 1'b0, 1'b1, B_GRB | B_ROUT | B_YIN | B_RUN, 5'd0, "stp_t3");
    chk(1'b1, I_ADD, 1'b0, 1'b1, B_GRC | B_ROUT | B_ZIN | B_RUN, 5'd3, "stp_t4");
    chk(1'b1, I_ADD, 1'b0, 1'b1, WB, 5'd0, "stp_t5");
    chk(1'b1, I_ADD, 1'b0, 1'b1, NONE, 5'd0, "stp_halt");
    for (int i = 0; i < 3; i++) chk(1'b1, I_ADD, 1'b0, 1'b0, NONE, 5'd0, "stp_hold");
    chk(1'b0, I_ADD, 1'b0, 1'b0, NONE, 5'd0, "stp_clr");
    chk(1'b1, I_ADD, 1'b0, 1'b0, NONE, 5'd0, "stp_rst");

    // halt opcode: T3 with no strobes, then sticky HALT until clr.
    chk(1'b1, I_HALT, 1'b0, 1'b0, F0, 5'd12, "hlt_t0");
    chk(1'b1, I_HALT, 1'b0, 1'b0, F1, 5'd0,  "hlt_t1");
    chk(1'b1, I_HALT, 1'b0, 1'b0, F2, 5'd0,  "hlt_t2");
    chk(1'b1, I_HALT, 1'b0, 1'b0, B_RUN, 5'd0, "hlt_t3");
    for (int i = 0; i < 10; i++) chk(1'b1, I_HALT, 1'b0, 1'b0, NONE, 5'd0, "hlt_hold");
    chk(1'b0, I_HALT, 1'b0, 1'b0, NONE, 5'd0, "hlt_clr");
    chk(1'b1, I_HALT, 1'b0, 1'b0, NONE, 5'd0, "hlt_rst");

    // clr asserted in T5 of an ld aborts the instruction.
    chk(1'b1, I_LD, 1'b0, 1'b0, F0, 5'd12, "abt_t0");
    chk(1'b1, I_LD, 1'b0, 1'b0, F1, 5'd0,  "abt_t1");
    chk(1'b1, I_LD, 1'b0, 1'b0, F2, 5'd0,  "abt_t2");
    chk(1'b1, I_LD, 1'b0, 1'b0, B_GRB | B_BAOUT | B_YIN | B_RUN, 5'd0, "abt_t3");
    chk(1'b1, I_LD, 1'b0, 1'b0, B_COUT | B_ZIN | B_RUN, 5'd3, "abt_t4");
    chk(1'b0, I_LD, 1'b0, 1'b0, B_ZLOW | B_MARIN | B_RUN, 5'd0, "abt_t5");
    chk(1'b1, I_LD, 1'b0, 1'b0, NONE, 5'd0, "abt_rst");
    chk(1'b1, I_LD, 1'b0, 1'b0, F0, 5'd12, "abt_t0b");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
